// File: rtl/ir_motion_gate.sv
// IR beam-break conditioner and motion-gate FSM.
// Synchronises and debounces the raw receiver, then holds freeze_out high for the
// duration of a beam break plus a hold window, pulsing event_out once per passage.
module ir_motion_gate #(
  parameter int DEBOUNCE_CYCLES = 7425,
  parameter int HOLD_CYCLES     = 7425000,
  parameter int LEN_WIDTH       = 24,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   ir_in,
  input  logic                   arm_in,
  output logic                   freeze_out,
  output logic                   event_out,
  output logic [COUNT_WIDTH-1:0] event_count_out,
  output logic [LEN_WIDTH-1:0]   break_len_out,
  output logic [1:0]             state_out
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
      $error("ir_motion_gate: DEBOUNCE_CYCLES and HOLD_CYCLES must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BREAK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  logic          sync_q, ir_s;
  logic          deb, deb_q;
  logic [DW-1:0] deb_cnt;
  logic          rise, fall;

  state_t                 state, state_nxt;
  logic [LEN_WIDTH-1:0]   len_cnt, len_nxt;
  logic [HW-1:0]          hold_cnt, hold_nxt;
  logic [LEN_WIDTH-1:0]   blen_nxt;
  logic [COUNT_WIDTH-1:0] cnt_nxt;
  logic                   evt_nxt;

  // Two-flop synchroniser, then a level filter: deb only follows ir_s once the
  // new level has persisted for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q  <= 1'b0;
      ir_s    <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_q <= ir_in;
      ir_s   <= sync_q;
      deb_q  <= deb;
      if (ir_s == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign rise = deb & ~deb_q;
  assign fall = ~deb & deb_q;

  // Next-state and datapath: disarm wins over everything; a re-break during HOLD
  // is treated as the same passage (no new event).
  always_comb begin
    state_nxt = state;
    len_nxt   = len_cnt;
    hold_nxt  = hold_cnt;
    blen_nxt  = break_len_out;
    cnt_nxt   = event_count_out;
    evt_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise && arm_in) begin
          state_nxt = S_BREAK;
          evt_nxt   = 1'b1;
          len_nxt   = LEN_WIDTH'(1);
          if (event_count_out != '1) cnt_nxt = event_count_out + COUNT_WIDTH'(1);
        end
      end
      S_BREAK: begin
        if (!arm_in) begin
          state_nxt = S_IDLE;
        end else if (fall) begin
          state_nxt = S_HOLD;
          blen_nxt  = len_cnt;
          hold_nxt  = '0;
        end else if (len_cnt != '1) begin
          len_nxt = len_cnt + LEN_WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (!arm_in) begin
          state_nxt = S_IDLE;
        end else if (rise) begin
          state_nxt = S_BREAK;
          len_nxt   = LEN_WIDTH'(1);
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= S_IDLE;
      len_cnt         <= '0;
      hold_cnt        <= '0;
      break_len_out   <= '0;
      event_count_out <= '0;
      event_out       <= 1'b0;
      freeze_out      <= 1'b0;
    end else begin
      state           <= state_nxt;
      len_cnt         <= len_nxt;
      hold_cnt        <= hold_nxt;
      break_len_out   <= blen_nxt;
      event_count_out <= cnt_nxt;
      event_out       <= evt_nxt;
      freeze_out      <= (state_nxt != S_IDLE);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_ir_motion_gate.sv
// Bench for ir_motion_gate: scripted scenarios plus random stimulus, all checked
// cycle by cycle against a window-filter / passage model of the gate.
module tb_ir_motion_gate;

  localparam int D    = 4;
  localparam int H    = 10;
  localparam int CW   = 2;
  localparam int LW   = 8;
  localparam int CMAX = 3;
  localparam int LMAX = 255;

  logic          clk_in = 1'b0;
  logic          rst_in, ir_in, arm_in;
  logic          freeze_out, event_out;
  logic [CW-1:0] event_count_out;
  logic [LW-1:0] break_len_out;
  logic [1:0]    state_out;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  ir_motion_gate #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .LEN_WIDTH(LW), .COUNT_WIDTH(CW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ir_in(ir_in), .arm_in(arm_in),
    .freeze_out(freeze_out), .event_out(event_out),
    .event_count_out(event_count_out), .break_len_out(break_len_out),
    .state_out(state_out)
  );

  // Reference model: debounced level is the common value of the last D
  // synchronised samples (else unchanged); the gate is described as a passage
  // that is frozen, possibly broken, and counts cycles since the beam returned.
  int hist[$];
  bit m_deb, m_deb_q, frozen, broken, evt;
  int since, len, blen, cnt;

  task model_update(input logic ir, input logic arm, input logic rst);
    bit rise, fall, same;
    bit nd;
    int c;
    if (rst) begin
      hist.delete();
      repeat (D + 1) hist.push_back(0);
      m_deb = 0; m_deb_q = 0; frozen = 0; broken = 0; evt = 0;
      since = 0; len = 0; blen = 0; cnt = 0;
      return;
    end
    rise = m_deb && !m_deb_q;
    fall = !m_deb && m_deb_q;
    evt  = 0;
    if (!arm) begin
      frozen = 0; broken = 0;
    end else if (!frozen) begin
      if (rise) begin
        frozen = 1; broken = 1; evt = 1; len = 1;
        if (cnt < CMAX) cnt++;
      end
    end else if (broken) begin
      if (fall) begin
        broken = 0; blen = len; since = 0;
      end else if (len < LMAX) len++;
    end else begin
      if (rise) begin
        broken = 1; len = 1;
      end else begin
        since++;
        if (since == H) frozen = 0;
      end
    end
    c = hist[1]; same = 1;
    for (int k = 1; k <= D; k++) if (hist[k] != c) same = 0;
    nd = same ? bit'(c) : m_deb;
    hist.push_front(int'(ir));
    void'(hist.pop_back());
    m_deb_q = m_deb;
    m_deb   = nd;
  endtask

  function automatic logic [13:0] dut_v();
    return {freeze_out, event_out, event_count_out, break_len_out, state_out};
  endfunction

  function automatic logic [13:0] mdl_v();
    logic [1:0] st;
    st = !frozen ? 2'd0 : (broken ? 2'd1 : 2'd2);
    return {frozen, evt, CW'(cnt), LW'(blen), st};
  endfunction

  task step(input logic ir, input logic arm, input logic rst);
    ir_in = ir; arm_in = arm; rst_in = rst;
    @(posedge clk_in);
    model_update(ir, arm, rst);
    #1;
  endtask

  task test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      total++;
      if (dut_v() !== 14'd0) begin
        bad++; $display("FAIL reset cyc=%0d got=%h want=0", i, dut_v());
      end
    end
  endtask

  task test_glitch;
    int ev_n = 0, fr_n = 0;
    for (int i = 0; i < 18; i++) begin
      step(i < 3, 1'b1, 1'b0);
      total++;
      if (dut_v() !== mdl_v()) begin
        bad++; $display("FAIL glitch_model cyc=%0d got=%h want=%h", i, dut_v(), mdl_v());
      end
      ev_n += event_out; fr_n += freeze_out;
    end
    total++;
    if (ev_n !== 0 || fr_n !== 0 || event_count_out !== 2'd0) begin
      bad++; $display("FAIL glitch ev=%0d fr=%0d cnt=%0d want 0/0/0", ev_n, fr_n, event_count_out);
    end
  endtask

  task test_single;
    int ev_n = 0, ev_at = -1, fr_n = 0;
    for (int i = 1; i <= 65; i++) begin
      step(i <= 20, 1'b1, 1'b0);
      total++;
      if (dut_v() !== mdl_v()) begin
        bad++; $display("FAIL single_model cyc=%0d got=%h want=%h", i, dut_v(), mdl_v());
      end
      if (event_out) begin ev_n++; ev_at = i; end
      fr_n += freeze_out;
    end
    total++;
    if (ev_n !== 1 || ev_at !== 7) begin
      bad++; $display("FAIL single_event n=%0d at=%0d want 1 at 7", ev_n, ev_at);
    end
    total++;
    if (fr_n !== 30) begin
      bad++; $display("FAIL single_freeze got=%0d want=30", fr_n);
    end
    total++;
    if (break_len_out !== 8'd20 || event_count_out !== 2'd1) begin
      bad++; $display("FAIL single_len len=%0d cnt=%0d want 20/1", break_len_out, event_count_out);
    end
  endtask

  task test_disarmed;
    int ev_n = 0, fr_n = 0;
    for (int i = 1; i <= 40; i++) begin
      step(i <= 20, 1'b0, 1'b0);
      total++;
      if (dut_v() !== mdl_v()) begin
        bad++; $display("FAIL disarm_model cyc=%0d got=%h want=%h", i, dut_v(), mdl_v());
      end
      ev_n += event_out; fr_n += freeze_out;
    end
    total++;
    if (ev_n !== 0 || fr_n !== 0 || event_count_out !== 2'd1) begin
      bad++; $display("FAIL disarm ev=%0d fr=%0d cnt=%0d want 0/0/1", ev_n, fr_n, event_count_out);
    end
  endtask

  task test_continuation;
    int ev_n = 0, fr_n = 0, fr_rises = 0;
    int lens[$];
    logic prev_fr = 1'b0;
    logic [1:0] prev_st = 2'd0;
    for (int i = 1; i <= 73; i++) begin
      step((i <= 20) || (i > 25 && i <= 33), 1'b1, 1'b0);
      total++;
      if (dut_v() !== mdl_v()) begin
        bad++; $display("FAIL cont_model cyc=%0d got=%h want=%h", i, dut_v(), mdl_v());
      end
      ev_n += event_out; fr_n += freeze_out;
      if (freeze_out && !prev_fr) fr_rises++;
      if (state_out == 2'd2 && prev_st == 2'd1) lens.push_back(int'(break_len_out));
      prev_fr = freeze_out; prev_st = state_out;
    end
    total++;
    if (ev_n !== 1 || fr_rises !== 1 || fr_n !== 43) begin
      bad++; $display("FAIL cont_freeze ev=%0d rises=%0d fr=%0d want 1/1/43", ev_n, fr_rises, fr_n);
    end
    total++;
    if (lens.size() !== 2 || lens[0] !== 20 || lens[1] !== 8) begin
      bad++; $display("FAIL cont_len n=%0d got=%p want 20,8", lens.size(), lens);
    end
  endtask

  task test_len_saturate;
    for (int i = 1; i <= 330; i++) begin
      step(i <= 300, 1'b1, 1'b0);
      total++;
      if (dut_v() !== mdl_v()) begin
        bad++; $display("FAIL lensat_model cyc=%0d got=%h want=%h", i, dut_v(), mdl_v());
      end
    end
    total++;
    if (break_len_out !== 8'd255) begin
      bad++; $display("FAIL len_saturate got=%0d want=255", break_len_out);
    end
  endtask

  task test_count_and_abort;
    int exp_cnt[4] = '{1, 2, 3, 3};
    int n;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int b = 0; b < 4; b++) begin
      for (int i = 1; i <= 36; i++) step(i <= 6, 1'b1, 1'b0);
      total++;
      if (event_count_out !== CW'(exp_cnt[b])) begin
        bad++; $display("FAIL count_sat brk=%0d got=%0d want=%0d", b, event_count_out, exp_cnt[b]);
      end
    end
    n = 0;
    while (state_out !== 2'd1 && n < 20) begin step(1'b1, 1'b1, 1'b0); n++; end
    total++;
    if (state_out !== 2'd1) begin
      bad++; $display("FAIL abort_enter state=%0d want 1 within 20 cycles", state_out);
    end
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (freeze_out !== 1'b0 || state_out !== 2'd0) begin
      bad++; $display("FAIL abort_drop frz=%0b st=%0d want 0/0", freeze_out, state_out);
    end
    for (int i = 0; i < 30; i++) step(i < 5, 1'b0, 1'b0);
    total++;
    if (break_len_out !== 8'd6 || dut_v() !== mdl_v()) begin
      bad++; $display("FAIL abort_len len=%0d got=%h want=6 model=%h", break_len_out, dut_v(), mdl_v());
    end
  endtask

  task test_mid_reset;
    int n = 0;
    while (freeze_out !== 1'b1 && n < 20) begin step(1'b1, 1'b1, 1'b0); n++; end
    total++;
    if (freeze_out !== 1'b1) begin
      bad++; $display("FAIL midrst_freeze got=%0b want=1 within 20 cycles", freeze_out);
    end
    step(1'b1, 1'b1, 1'b1);
    total++;
    if (dut_v() !== 14'd0) begin
      bad++; $display("FAIL midrst got=%h want=0", dut_v());
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task test_random;
    logic lvl = 1'b0;
    int   run = 0;
    for (int i = 0; i < 800; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = (lvl) ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 16));
      end
      run--;
      step(lvl, ($urandom_range(0, 39) != 0), 1'b0);
      total++;
      if (dut_v() !== mdl_v()) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_v(), mdl_v());
      end
    end
  endtask

  initial begin
    rst_in = 1'b1; ir_in = 1'b0; arm_in = 1'b0;
    test_reset;
    test_glitch;
    test_single;
    test_disarmed;
    test_continuation;
    test_len_saturate;
    test_count_and_abort;
    test_mid_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
